// File: rtl/nios2_ocimem_access_arbiter_if.sv
// Bus bundle for the OCI RAM access arbiter: JTAG command strobes, CPU debug
// master, single-port RAM and monitor status. The arbiter uses the master side.
interface nios2_ocimem_access_arbiter_if #(
  parameter int ADDR_W = 8
);
  // JTAG debug-module command strobes
  logic              take_action_ocimem_a;
  logic              take_action_ocimem_b;
  logic              take_no_action_ocimem_a;
  logic [37:0]       jdo;

  // CPU debug data master
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [3:0]        cpu_be;
  logic              cpu_grant;
  logic              cpu_rvalid;
  logic [31:0]       cpu_rdata;

  // Single-port OCI RAM
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [3:0]        ram_be;
  logic [31:0]       ram_rdata;

  // Monitor status
  logic [31:0]       MonDReg;
  logic              monitor_ready;
  logic              cmd_overrun;

  modport master (
    input  take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a, jdo,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
    output cpu_grant, cpu_rvalid, cpu_rdata,
    output ram_en, ram_we, ram_addr, ram_wdata, ram_be,
    input  ram_rdata,
    output MonDReg, monitor_ready, cmd_overrun
  );

  modport slave (
    output take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a, jdo,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
    input  cpu_grant, cpu_rvalid, cpu_rdata,
    input  ram_en, ram_we, ram_addr, ram_wdata, ram_be,
    output ram_rdata,
    input  MonDReg, monitor_ready, cmd_overrun
  );
endinterface

// File: rtl/nios2_ocimem_access_arbiter.sv
// Shares the single-port OCI RAM between the CPU debug master and JTAG commands:
// CPU has priority, but a pending JTAG command wins after STARVE_LIMIT CPU grants.
module nios2_ocimem_access_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                           clk,
  input  logic                           reset_n,
  nios2_ocimem_access_arbiter_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RDATA = 2'd2
  } state_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_e            state_q, state_d;
  logic              grant_cpu, grant_jtag;

  logic [ADDR_W-1:0] jtag_addr_q, jtag_addr_d;
  logic              pending_q, pending_d;
  logic              pend_we_q;
  logic [31:0]       pend_wdata_q;
  logic [3:0]        starve_cnt_q, starve_cnt_d;

  logic              src_jtag_q;
  logic              acc_we_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [31:0]       ram_wdata_q;
  logic [3:0]        ram_be_q;

  logic [31:0]       mon_dreg_q;
  logic              monitor_ready_q;
  logic              cmd_overrun_q;

  logic              cmd_rd, cmd_wr, cmd_any, cmd_accept, cmd_drop;
  logic              unused_jdo;

  // ---------------------------------------------------------------------------
  // JTAG command decode. An address load masks a same-cycle auto-increment read;
  // its own read flag decides whether a read is queued at the new address.
  // ---------------------------------------------------------------------------
  assign cmd_rd  = bus.take_action_ocimem_a ? bus.jdo[34] : bus.take_no_action_ocimem_a;
  assign cmd_wr  = bus.take_action_ocimem_b;
  assign cmd_any = cmd_rd | cmd_wr;

  // The slot frees in the JTAG grant cycle, so a command arriving then is kept.
  // A read and a write in the same cycle cannot both fit; the write is kept.
  assign cmd_accept = cmd_any & (~pending_q | grant_jtag);
  assign cmd_drop   = (cmd_any & pending_q & ~grant_jtag) | (cmd_rd & cmd_wr);

  assign unused_jdo = ^{bus.jdo[37:35], bus.jdo[2:0]};

  // ---------------------------------------------------------------------------
  // Arbitration FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples its pre-edge value regardless of statement order.
      state_q <= state_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves
    // a variable unassigned and no latch is inferred.
    state_d      = state_q;
    grant_cpu    = 1'b0;
    grant_jtag   = 1'b0;
    starve_cnt_d = starve_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (bus.cpu_req && pending_q) begin
          if (starve_cnt_q == LIMIT) begin
            grant_jtag = 1'b1;
          end else begin
            grant_cpu    = 1'b1;
            starve_cnt_d = starve_cnt_q + 4'd1;
          end
        end else if (bus.cpu_req) begin
          grant_cpu = 1'b1;
        end else if (pending_q) begin
          grant_jtag = 1'b1;
        end

        if (grant_jtag) starve_cnt_d = '0;
        if (grant_cpu || grant_jtag) state_d = ISSUE;
      end
      ISSUE:   state_d = acc_we_q ? IDLE : RDATA;
      RDATA:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Command slot and JTAG address pointer
  // ---------------------------------------------------------------------------
  always_comb begin
    pending_d = pending_q & ~grant_jtag;
    if (cmd_accept) pending_d = 1'b1;

    // The pointer advances as the JTAG access is granted; an address load wins.
    jtag_addr_d = jtag_addr_q;
    if (grant_jtag)               jtag_addr_d = jtag_addr_q + ADDR_W'(1);
    if (bus.take_action_ocimem_a) jtag_addr_d = bus.jdo[ADDR_W+16:17];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      jtag_addr_q     <= '0;
      pending_q       <= 1'b0;
      pend_we_q       <= 1'b0;
      pend_wdata_q    <= '0;
      starve_cnt_q    <= '0;
      monitor_ready_q <= 1'b1;
      cmd_overrun_q   <= 1'b0;
    end else begin
      jtag_addr_q     <= jtag_addr_d;
      pending_q       <= pending_d;
      starve_cnt_q    <= starve_cnt_d;
      monitor_ready_q <= ~pending_d;
      if (cmd_accept) begin
        pend_we_q    <= cmd_wr;
        pend_wdata_q <= bus.jdo[34:3];
      end
      if (cmd_drop) cmd_overrun_q <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // RAM cycle registers, captured from the granted source
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src_jtag_q  <= 1'b0;
      acc_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_be_q    <= '0;
      mon_dreg_q  <= '0;
    end else begin
      if (grant_cpu) begin
        src_jtag_q  <= 1'b0;
        acc_we_q    <= bus.cpu_we;
        ram_addr_q  <= bus.cpu_addr;
        ram_wdata_q <= bus.cpu_wdata;
        ram_be_q    <= bus.cpu_be;
      end else if (grant_jtag) begin
        src_jtag_q  <= 1'b1;
        acc_we_q    <= pend_we_q;
        ram_addr_q  <= jtag_addr_q;
        ram_wdata_q <= pend_wdata_q;
        ram_be_q    <= 4'hF;
      end

      if (state_q == RDATA && src_jtag_q) mon_dreg_q <= bus.ram_rdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: strobes decode the state register, so a reset aborts them at once
  // ---------------------------------------------------------------------------
  assign bus.ram_en        = (state_q == ISSUE);
  assign bus.ram_we        = (state_q == ISSUE) & acc_we_q;
  assign bus.ram_addr      = ram_addr_q;
  assign bus.ram_wdata     = ram_wdata_q;
  assign bus.ram_be        = ram_be_q;

  assign bus.cpu_grant     = (state_q == ISSUE) & ~src_jtag_q;
  assign bus.cpu_rvalid    = (state_q == RDATA) & ~src_jtag_q;
  assign bus.cpu_rdata     = bus.ram_rdata;

  assign bus.MonDReg       = mon_dreg_q;
  assign bus.monitor_ready = monitor_ready_q;
  assign bus.cmd_overrun   = cmd_overrun_q;

endmodule
